tdc_tsfifo: RTL

- Timestamp buffer directly downstream of the TDC core channel output.
- Captures each detect pulse (timestamp + polarity) into a FIFO.
- Presents the FIFO to the LM32 as a 32-bit Wishbone slave, with an interrupt line that goes into the CPU interrupt vector.
- Decouples TDC event bursts from slow software readout and counts events lost to overflow.

---
 rtl/tdc_tsfifo.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/tdc_tsfifo.sv
// tdc_tsfifo
// Timestamp FIFO between the TDC core and the LM32. Every detect strobe stores
// {polarity, timestamp}. Software drains the FIFO through a 32-bit Wishbone
// slave and can take a level-sensitive interrupt. Events that arrive while
// the FIFO is full are dropped; they set a sticky overflow flag and advance a
// saturating drop counter.
//
// Ports:
//   wb_clk_i, rst_n_i          clock, asynchronous active-low reset
//   detect_i, polarity_i,
//   value_i                    event strobe, edge polarity, timestamp
//   wb_addr_i, wb_data_i,
//   wb_cyc_i, wb_stb_i,
//   wb_we_i, wb_sel_i          Wishbone slave inputs (wb_sel_i is ignored)
//   wb_data_o, wb_ack_o        Wishbone read data and acknowledge
//   wb_irq_o                   interrupt: level >= threshold while enabled
//
// Register map (word address):
//   0 STATUS  [0] empty [1] full [2] ovf [15:8] level [31:16] drop count
//   1 CTRL    [7:0] threshold [8] irq_en [9] clear ovf/drops [10] flush
//   2 TS_LO   head value[31:0], no pop
//   3 TS_HI   head value[W-1:32], [30] polarity, [31] valid; pops the head
module tdc_tsfifo #(
    parameter int g_TS_WIDTH   = 38,
    parameter int g_DEPTH_LOG2 = 4
) (
    input  logic                  wb_clk_i,
    input  logic                  rst_n_i,
    input  logic                  detect_i,
    input  logic                  polarity_i,
    input  logic [g_TS_WIDTH-1:0] value_i,
    input  logic [1:0]            wb_addr_i,
    input  logic [31:0]           wb_data_i,
    output logic [31:0]           wb_data_o,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [3:0]            wb_sel_i,
    output logic                  wb_ack_o,
    output logic                  wb_irq_o
);

    localparam int DEPTH = 1 << g_DEPTH_LOG2;
    localparam int LW    = g_DEPTH_LOG2 + 1;
    localparam int HIW   = g_TS_WIDTH - 32;

    logic [g_TS_WIDTH:0]     mem [DEPTH];
    logic [g_DEPTH_LOG2-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [LW-1:0]           level_q, level_d;
    logic                    ovf_q, ovf_d;
    logic [15:0]             dropCnt_q, dropCnt_d;
    logic [7:0]              thr_q;
    logic                    irqEn_q;
    logic                    ack_q;
    logic [31:0]             data_q;
    logic                    irq_q;
    logic                    popPend_q;

    logic                    access, rdAccess, ctrlWr, flush, clear;
    logic                    empty, full, pop, pushOk, drop;
    logic [g_TS_WIDTH:0]     head;
    logic [31:0]             rdData, status, tsHi;
    logic [7:0]              levelExt, thrEff;
    logic [21:0]             sel_unused;

    assign sel_unused = {wb_sel_i, wb_data_i[31:14]} ^ {18'd0, wb_data_i[13:11], 1'b0};

    assign access   = wb_cyc_i & wb_stb_i & ~ack_q;
    assign rdAccess = access & ~wb_we_i;
    assign ctrlWr   = access & wb_we_i & (wb_addr_i == 2'd1);
    assign flush    = ctrlWr & wb_data_i[10];
    assign clear    = ctrlWr & wb_data_i[9];

    assign empty  = (level_q == '0);
    assign full   = (level_q == LW'(DEPTH));
    // The TS_HI pop is committed in the ack cycle; the head was already
    // captured into wb_data_o, so a same-cycle push may reuse its slot.
    assign pop    = popPend_q;
    assign pushOk = detect_i & (~full | pop);
    assign drop   = detect_i & full & ~pop;

    assign head     = mem[rdPtr_q];
    assign levelExt = 8'(level_q);
    assign thrEff   = (thr_q == 8'd0) ? 8'd1 : thr_q;

    // Pointer, level and overflow bookkeeping; flush and clear take priority.
    always_comb begin
        wrPtr_d   = wrPtr_q;
        rdPtr_d   = rdPtr_q;
        level_d   = level_q;
        ovf_d     = ovf_q;
        dropCnt_d = dropCnt_q;
        if (flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            level_d = '0;
        end else begin
            if (pushOk) wrPtr_d = wrPtr_q + 1'b1;
            if (pop)    rdPtr_d = rdPtr_q + 1'b1;
            if (pushOk && !pop)      level_d = level_q + LW'(1);
            else if (!pushOk && pop) level_d = level_q - LW'(1);
        end
        if (clear) begin
            ovf_d     = 1'b0;
            dropCnt_d = '0;
        end else if (drop && !flush) begin
            ovf_d = 1'b1;
            if (dropCnt_q != 16'hFFFF) dropCnt_d = dropCnt_q + 16'd1;
        end
    end

    // Read data mux, sampled into wb_data_o on the edge that raises ack.
    always_comb begin
        status          = '0;
        status[0]       = empty;
        status[1]       = full;
        status[2]       = ovf_q;
        status[8 +: LW] = level_q;
        status[31:16]   = dropCnt_q;

        tsHi = '0;
        if (!empty) begin
            tsHi[HIW-1:0] = head[g_TS_WIDTH-1:32];
            tsHi[30]      = head[g_TS_WIDTH];
            tsHi[31]      = 1'b1;
        end

        rdData = '0;
        case (wb_addr_i)
            2'd0: rdData = status;
            2'd1: rdData = {23'd0, irqEn_q, thr_q};
            2'd2: rdData = empty ? 32'd0 : head[31:0];
            2'd3: rdData = tsHi;
            default: rdData = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (pushOk && !flush) mem[wrPtr_q] <= {polarity_i, value_i};
    end

    always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            level_q   <= '0;
            ovf_q     <= 1'b0;
            dropCnt_q <= '0;
            thr_q     <= 8'd1;
            irqEn_q   <= 1'b0;
            ack_q     <= 1'b0;
            data_q    <= '0;
            irq_q     <= 1'b0;
            popPend_q <= 1'b0;
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            level_q   <= level_d;
            ovf_q     <= ovf_d;
            dropCnt_q <= dropCnt_d;
            ack_q     <= wb_cyc_i & wb_stb_i & ~ack_q;
            data_q    <= rdAccess ? rdData : 32'd0;
            popPend_q <= rdAccess & (wb_addr_i == 2'd3) & ~empty;
            if (ctrlWr) begin
                thr_q   <= wb_data_i[7:0];
                irqEn_q <= wb_data_i[8];
            end
            irq_q <= irqEn_q & (levelExt >= thrEff);
        end
    end

    assign wb_ack_o  = ack_q;
    assign wb_data_o = data_q;
    assign wb_irq_o  = irq_q;

endmodule
